tx_session_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single TCP TX path (tx_metadata / tx_status / tx_data) among NUM_REQ result producers, e.g. several top-k kernels. For each packet it issues the TX metadata request, waits for the stack's status, then forwards or discards exactly the announced number of 64-byte beats. It sits between the producers and the network stack's TX interfaces.

---
 rtl/tx_session_arbiter_if.sv | 57 +++++
 rtl/tx_session_arbiter.sv | 172 +++++++++++++++++
 tb/tb_tx_session_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_session_arbiter_if.sv
// Bundle of the producer-side and stack-side streams around the TX session arbiter.
// The master modport is the arbiter's view; slave is the view of whatever drives
// the producers and emulates the network stack.
interface tx_session_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ*32-1:0]  req_meta_TDATA;
    logic [NUM_REQ-1:0]     req_meta_TVALID;
    logic [NUM_REQ-1:0]     req_meta_TREADY;

    logic [NUM_REQ*512-1:0] req_data_TDATA;
    logic [NUM_REQ-1:0]     req_data_TLAST;
    logic [NUM_REQ-1:0]     req_data_TVALID;
    logic [NUM_REQ-1:0]     req_data_TREADY;

    logic [31:0]            m_axis_tx_metadata_TDATA;
    logic                   m_axis_tx_metadata_TVALID;
    logic                   m_axis_tx_metadata_TREADY;

    logic [63:0]            s_axis_tx_status_TDATA;
    logic                   s_axis_tx_status_TVALID;
    logic                   s_axis_tx_status_TREADY;

    logic [511:0]           m_axis_tx_data_TDATA;
    logic [63:0]            m_axis_tx_data_TKEEP;
    logic                   m_axis_tx_data_TLAST;
    logic                   m_axis_tx_data_TVALID;
    logic                   m_axis_tx_data_TREADY;

    modport master (
        input  req_meta_TDATA, req_meta_TVALID,
        output req_meta_TREADY,
        input  req_data_TDATA, req_data_TLAST, req_data_TVALID,
        output req_data_TREADY,
        output m_axis_tx_metadata_TDATA, m_axis_tx_metadata_TVALID,
        input  m_axis_tx_metadata_TREADY,
        input  s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
        output s_axis_tx_status_TREADY,
        output m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP,
        output m_axis_tx_data_TLAST, m_axis_tx_data_TVALID,
        input  m_axis_tx_data_TREADY
    );

    modport slave (
        output req_meta_TDATA, req_meta_TVALID,
        input  req_meta_TREADY,
        output req_data_TDATA, req_data_TLAST, req_data_TVALID,
        input  req_data_TREADY,
        input  m_axis_tx_metadata_TDATA, m_axis_tx_metadata_TVALID,
        output m_axis_tx_metadata_TREADY,
        output s_axis_tx_status_TDATA, s_axis_tx_status_TVALID,
        input  s_axis_tx_status_TREADY,
        input  m_axis_tx_data_TDATA, m_axis_tx_data_TKEEP,
        input  m_axis_tx_data_TLAST, m_axis_tx_data_TVALID,
        output m_axis_tx_data_TREADY
    );
endinterface

// File: rtl/tx_session_arbiter.sv
// Packet-granular round-robin arbiter sharing one TCP TX path among NUM_REQ
// producers. Each packet: grant, send metadata, wait for status, then forward
// (status ok) or discard (closed connection) exactly len_beats payload beats.
module tx_session_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    tx_session_arbiter_if.master      bus,
    output logic [31:0]               pkt_sent_cnt,
    output logic [31:0]               pkt_drop_cnt,
    output logic                      protocol_err
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        META,
        STATUS,
        DATA,
        DRAIN
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_grant;
    logic [9:0]    r_count;
    logic [31:0]   r_meta;
    logic [31:0]   r_sent_cnt;
    logic [31:0]   r_drop_cnt;
    logic          r_protocol_err;

    logic          w_any;
    logic [PW-1:0] w_grant;
    logic [31:0]   w_meta_sel;
    logic [PW-1:0] w_ptr_next;
    logic          w_last;
    logic          w_accept;
    logic          w_status_unused;

    // Only bit 62 of the status word carries meaning for us.
    assign w_status_unused = ^{bus.s_axis_tx_status_TDATA[63], bus.s_axis_tx_status_TDATA[61:0]};

    assign w_meta_sel = bus.req_meta_TDATA[32*w_grant +: 32];
    assign w_ptr_next = (r_grant == PW'(NUM_REQ - 1)) ? '0 : r_grant + PW'(1);
    assign w_last     = (r_count == 10'd1);

    assign bus.m_axis_tx_metadata_TDATA = r_meta;
    assign bus.m_axis_tx_data_TKEEP     = '1;
    assign bus.m_axis_tx_data_TDATA     = bus.req_data_TDATA[512*r_grant +: 512];

    assign pkt_sent_cnt = r_sent_cnt;
    assign pkt_drop_cnt = r_drop_cnt;
    assign protocol_err = r_protocol_err;

    // Round-robin pick: scan downward so the requester closest above ptr wins last.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_meta_TVALID[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_any   = 1'b1;
                w_grant = PW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    // State register; a reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake steering; the data path is purely combinational.
    always_comb begin
        w_state_next                  = r_state;
        w_accept                      = 1'b0;
        bus.req_meta_TREADY           = '0;
        bus.req_data_TREADY           = '0;
        bus.m_axis_tx_metadata_TVALID = 1'b0;
        bus.s_axis_tx_status_TREADY   = 1'b0;
        bus.m_axis_tx_data_TVALID     = 1'b0;
        bus.m_axis_tx_data_TLAST      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    bus.req_meta_TREADY[w_grant] = 1'b1;
                    w_state_next                 = META;
                end
            end
            META: begin
                bus.m_axis_tx_metadata_TVALID = 1'b1;
                if (bus.m_axis_tx_metadata_TREADY) begin
                    w_state_next = STATUS;
                end
            end
            STATUS: begin
                bus.s_axis_tx_status_TREADY = 1'b1;
                if (bus.s_axis_tx_status_TVALID) begin
                    w_state_next = bus.s_axis_tx_status_TDATA[62] ? DRAIN : DATA;
                end
            end
            DATA: begin
                bus.m_axis_tx_data_TVALID    = bus.req_data_TVALID[r_grant];
                bus.req_data_TREADY[r_grant] = bus.m_axis_tx_data_TREADY;
                bus.m_axis_tx_data_TLAST     = w_last;
                w_accept = bus.req_data_TVALID[r_grant] && bus.m_axis_tx_data_TREADY;
                if (w_accept && w_last) begin
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                bus.req_data_TREADY[r_grant] = 1'b1;
                w_accept = bus.req_data_TVALID[r_grant];
                if (w_accept && w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Packet bookkeeping: grant capture, beat countdown, statistics and TLAST checking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr          <= '0;
            r_grant        <= '0;
            r_count        <= '0;
            r_meta         <= '0;
            r_sent_cnt     <= '0;
            r_drop_cnt     <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_count <= w_meta_sel[25:16];
                        r_meta  <= {w_meta_sel[25:16], 6'b0, w_meta_sel[15:0]};
                    end
                end
                STATUS: begin
                    if (bus.s_axis_tx_status_TVALID && bus.s_axis_tx_status_TDATA[62]) begin
                        r_drop_cnt <= r_drop_cnt + 32'd1;
                    end
                end
                DATA, DRAIN: begin
                    if (w_accept) begin
                        r_count <= r_count - 10'd1;
                        if (bus.req_data_TLAST[r_grant] != w_last) begin
                            r_protocol_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_ptr <= w_ptr_next;
                            if (r_state == DATA) begin
                                r_sent_cnt <= r_sent_cnt + 32'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_session_arbiter.sv
// Directed bench for tx_session_arbiter: reset, single packet, fairness,
// error status drain, backpressure, TLAST mismatch and reset mid-packet.
module tb_tx_session_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pkt_sent_cnt;
    logic [31:0] pkt_drop_cnt;
    logic        protocol_err;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] obsGrant;
    logic [31:0]  obsMeta;
    logic         obsMetaValid;
    logic         obsStatusReady;
    logic [511:0] obsData[$];
    logic         obsLast[$];
    logic         obsErr[$];
    int           obsAccepted;
    int           obsMirrorBad;
    int           obsDrainValid;
    bit           obsTimeout;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    tx_session_arbiter_if #(.NUM_REQ(N)) bus();

    tx_session_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master),
        .pkt_sent_cnt (pkt_sent_cnt),
        .pkt_drop_cnt (pkt_drop_cnt),
        .protocol_err (protocol_err)
    );

    function automatic logic [511:0] payload(input int r, input int b);
        logic [7:0] rr;
        logic [7:0] bb;
        rr = r[7:0];
        bb = b[7:0];
        return {16{rr, bb, 16'hA5C3}};
    endfunction

    task automatic clearInputs();
        bus.req_meta_TDATA            = '0;
        bus.req_meta_TVALID           = '0;
        bus.req_data_TDATA            = '0;
        bus.req_data_TLAST            = '0;
        bus.req_data_TVALID           = '0;
        bus.m_axis_tx_metadata_TREADY = 1'b0;
        bus.s_axis_tx_status_TDATA    = '0;
        bus.s_axis_tx_status_TVALID   = 1'b0;
        bus.m_axis_tx_data_TREADY     = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays producer and stack for one packet and records what the DUT did.
    task automatic drivePacket(input int req, input logic [N-1:0] mask, input int lenBeats,
                               input logic [15:0] session, input logic statusErr,
                               input int lastBeat, input bit toggle, input int abortAfter);
        int cyc;
        int target;
        bit stop;
        obsData.delete();
        obsLast.delete();
        obsErr.delete();
        obsAccepted   = 0;
        obsMirrorBad  = 0;
        obsDrainValid = 0;
        obsTimeout    = 0;
        target = (abortAfter > 0) ? abortAfter : lenBeats;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                bus.req_meta_TVALID[i]          = 1'b1;
                bus.req_meta_TDATA[32*i +: 32]  = {lenBeats[15:0], session};
            end
        end
        #1 obsGrant = bus.req_meta_TREADY;
        @(negedge clk);
        bus.req_meta_TVALID           = '0;
        bus.m_axis_tx_metadata_TREADY = 1'b1;
        #1;
        obsMeta      = bus.m_axis_tx_metadata_TDATA;
        obsMetaValid = bus.m_axis_tx_metadata_TVALID;
        @(negedge clk);
        bus.m_axis_tx_metadata_TREADY = 1'b0;
        bus.s_axis_tx_status_TVALID   = 1'b1;
        bus.s_axis_tx_status_TDATA    = 64'h0000_0000_DEAD_BEEF;
        bus.s_axis_tx_status_TDATA[62] = statusErr;
        #1 obsStatusReady = bus.s_axis_tx_status_TREADY;
        cyc  = 0;
        stop = 0;
        while (!stop) begin
            @(negedge clk);
            bus.s_axis_tx_status_TVALID        = 1'b0;
            bus.req_data_TVALID[req]           = 1'b1;
            bus.req_data_TDATA[512*req +: 512] = payload(req, obsAccepted);
            bus.req_data_TLAST[req]            = (obsAccepted + 1 == lastBeat);
            bus.m_axis_tx_data_TREADY          = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (bus.m_axis_tx_data_TVALID && bus.m_axis_tx_data_TREADY) begin
                obsData.push_back(bus.m_axis_tx_data_TDATA);
                obsLast.push_back(bus.m_axis_tx_data_TLAST);
                obsErr.push_back(protocol_err);
            end
            if (!statusErr && (bus.req_data_TREADY[req] !== bus.m_axis_tx_data_TREADY))
                obsMirrorBad++;
            if (statusErr && (bus.m_axis_tx_data_TVALID !== 1'b0))
                obsDrainValid++;
            if (bus.req_data_TREADY[req] === 1'b1)
                obsAccepted++;
            cyc++;
            if (obsAccepted >= target || cyc >= 64)
                stop = 1;
        end
        obsTimeout = (obsAccepted < target);
        if (abortAfter == 0) begin
            @(posedge clk);
            #1 clearInputs();
        end
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.m_axis_tx_metadata_TVALID, bus.s_axis_tx_status_TREADY, bus.m_axis_tx_data_TVALID,
             bus.req_meta_TREADY, bus.req_data_TREADY} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_handshakes got=%b want=0", {bus.m_axis_tx_metadata_TVALID,
                     bus.s_axis_tx_status_TREADY, bus.m_axis_tx_data_TVALID, bus.req_meta_TREADY, bus.req_data_TREADY});
        end
        total++;
        if (bus.m_axis_tx_metadata_TDATA !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_meta_data got=%h want=0", bus.m_axis_tx_metadata_TDATA);
        end
        total++;
        if ({pkt_sent_cnt, pkt_drop_cnt, protocol_err} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_counters got sent=%0d drop=%0d err=%b want 0", pkt_sent_cnt, pkt_drop_cnt, protocol_err);
        end
        total++;
        if (bus.m_axis_tx_data_TKEEP !== {64{1'b1}}) begin
            bad++;
            $display("[TB] FAIL reset_tkeep got=%h want=all ones", bus.m_axis_tx_data_TKEEP);
        end
    endtask

    task automatic test_single_packet();
        drivePacket(0, 4'b0001, 4, 16'h0012, 1'b0, 4, 1'b0, 0);
        total++;
        if (obsGrant !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL single_grant got=%b want=0001", obsGrant);
        end
        total++;
        if (obsMeta !== 32'h0100_0012 || obsMetaValid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_meta got=%h valid=%b want=01000012 valid=1", obsMeta, obsMetaValid);
        end
        total++;
        if (obsStatusReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_status_ready got=%b want=1", obsStatusReady);
        end
        total++;
        if (obsTimeout || obsData.size() != 4) begin
            bad++;
            $display("[TB] FAIL single_beats got=%0d timeout=%0d want=4", obsData.size(), obsTimeout);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (obsData[k] !== payload(0, k) || obsLast[k] !== (k == 3)) begin
                    bad++;
                    $display("[TB] FAIL single_beat%0d got last=%b data=%h want last=%b", k, obsLast[k], obsData[k][31:0], (k == 3));
                end
            end
        end
        total++;
        if (pkt_sent_cnt !== 32'd1 || pkt_drop_cnt !== 32'd0) begin
            bad++;
            $display("[TB] FAIL single_counts got sent=%0d drop=%0d want 1/0", pkt_sent_cnt, pkt_drop_cnt);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] expGrant;
        doReset();
        for (int p = 0; p < 8; p++) begin
            expGrant = 4'b0001 << (p % 4);
            drivePacket(p % 4, 4'b1111, 2, 16'h0100 + 16'(p), 1'b0, 2, 1'b0, 0);
            total++;
            if (obsGrant !== expGrant) begin
                bad++;
                $display("[TB] FAIL fair_grant%0d got=%b want=%b", p, obsGrant, expGrant);
            end
            total++;
            if (obsMeta !== {16'd128, 16'h0100 + 16'(p)} || obsData.size() != 2 || obsTimeout) begin
                bad++;
                $display("[TB] FAIL fair_pkt%0d got meta=%h beats=%0d want meta=%h beats=2", p, obsMeta, obsData.size(),
                         {16'd128, 16'h0100 + 16'(p)});
            end
        end
        total++;
        if (pkt_sent_cnt !== 32'd8) begin
            bad++;
            $display("[TB] FAIL fair_sent got=%0d want=8", pkt_sent_cnt);
        end
    endtask

    task automatic test_error_status();
        drivePacket(2, 4'b0100, 3, 16'h0BAD, 1'b1, 3, 1'b0, 0);
        total++;
        if (obsGrant !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL err_grant got=%b want=0100", obsGrant);
        end
        total++;
        if (obsAccepted != 3 || obsTimeout || obsData.size() != 0 || obsDrainValid != 0) begin
            bad++;
            $display("[TB] FAIL err_drain got accepted=%0d fwd=%0d mvalid=%0d want 3/0/0", obsAccepted, obsData.size(), obsDrainValid);
        end
        total++;
        if (pkt_drop_cnt !== 32'd1 || pkt_sent_cnt !== 32'd8) begin
            bad++;
            $display("[TB] FAIL err_counts got drop=%0d sent=%0d want 1/8", pkt_drop_cnt, pkt_sent_cnt);
        end
        drivePacket(3, 4'b1111, 2, 16'h0033, 1'b0, 2, 1'b0, 0);
        total++;
        if (obsGrant !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL err_ptr_next got=%b want=1000", obsGrant);
        end
    endtask

    task automatic test_backpressure();
        drivePacket(1, 4'b0010, 8, 16'h0777, 1'b0, 8, 1'b1, 0);
        total++;
        if (obsGrant !== 4'b0010 || obsMeta !== 32'h0200_0777) begin
            bad++;
            $display("[TB] FAIL bp_meta got grant=%b meta=%h want 0010/02000777", obsGrant, obsMeta);
        end
        total++;
        if (obsMirrorBad != 0) begin
            bad++;
            $display("[TB] FAIL bp_mirror got=%0d want=0", obsMirrorBad);
        end
        total++;
        if (obsTimeout || obsData.size() != 8) begin
            bad++;
            $display("[TB] FAIL bp_beats got=%0d want=8", obsData.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (obsData[k] !== payload(1, k) || obsLast[k] !== (k == 7)) begin
                    bad++;
                    $display("[TB] FAIL bp_beat%0d got last=%b data=%h want last=%b", k, obsLast[k], obsData[k][31:0], (k == 7));
                end
            end
        end
        total++;
        if (pkt_sent_cnt !== 32'd10) begin
            bad++;
            $display("[TB] FAIL bp_sent got=%0d want=10", pkt_sent_cnt);
        end
    endtask

    task automatic test_tlast_mismatch();
        logic [3:0] gotLast;
        logic [3:0] gotErr;
        total++;
        if (protocol_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL tlast_pre_err got=%b want=0", protocol_err);
        end
        drivePacket(3, 4'b1000, 4, 16'h0044, 1'b0, 2, 1'b0, 0);
        total++;
        if (obsGrant !== 4'b1000 || obsTimeout || obsData.size() != 4) begin
            bad++;
            $display("[TB] FAIL tlast_pkt got grant=%b beats=%0d want 1000/4", obsGrant, obsData.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                gotLast[k] = obsLast[k];
                gotErr[k]  = obsErr[k];
            end
            total++;
            if (gotLast !== 4'b1000) begin
                bad++;
                $display("[TB] FAIL tlast_out got=%b want=1000", gotLast);
            end
            total++;
            if (gotErr !== 4'b1100) begin
                bad++;
                $display("[TB] FAIL tlast_err_timing got=%b want=1100", gotErr);
            end
        end
        total++;
        if (protocol_err !== 1'b1 || pkt_sent_cnt !== 32'd11) begin
            bad++;
            $display("[TB] FAIL tlast_sticky got err=%b sent=%0d want 1/11", protocol_err, pkt_sent_cnt);
        end
    endtask

    task automatic test_reset_mid_data();
        drivePacket(2, 4'b0100, 5, 16'h0055, 1'b0, 5, 1'b0, 2);
        total++;
        if (obsData.size() != 2) begin
            bad++;
            $display("[TB] FAIL rstmid_partial got=%0d want=2", obsData.size());
        end
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({bus.m_axis_tx_metadata_TVALID, bus.s_axis_tx_status_TREADY, bus.m_axis_tx_data_TVALID,
             bus.req_meta_TREADY, bus.req_data_TREADY, bus.m_axis_tx_metadata_TDATA} !== '0) begin
            bad++;
            $display("[TB] FAIL rstmid_outputs got meta=%h mvalid=%b dvalid=%b want 0", bus.m_axis_tx_metadata_TDATA,
                     bus.m_axis_tx_metadata_TVALID, bus.m_axis_tx_data_TVALID);
        end
        total++;
        if ({pkt_sent_cnt, pkt_drop_cnt, protocol_err} !== '0) begin
            bad++;
            $display("[TB] FAIL rstmid_counters got sent=%0d drop=%0d err=%b want 0", pkt_sent_cnt, pkt_drop_cnt, protocol_err);
        end
        drivePacket(1, 4'b0010, 2, 16'h0011, 1'b0, 2, 1'b0, 0);
        total++;
        if (obsGrant !== 4'b0010 || obsData.size() != 2 || pkt_sent_cnt !== 32'd1) begin
            bad++;
            $display("[TB] FAIL rstmid_after got grant=%b beats=%0d sent=%0d want 0010/2/1", obsGrant, obsData.size(), pkt_sent_cnt);
        end
    endtask

    // Scenario sequence; each task leaves the arbiter idle for the next.
    initial begin
        test_reset();
        test_single_packet();
        test_fairness();
        test_error_status();
        test_backpressure();
        test_tlast_mismatch();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the DUT wedges a handshake the bench does not bound.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
